spi_mem_bridge: RTL
===================

// Module: spi_mem_bridge
// PURPOSE
//  Arbitrates CPU instruction-fetch and data-access requests onto the single SPI
//  memory engine (spi). Drives start/write/address/databus, holds them stable for the
//  whole transaction, waits for done, returns the byte to the winning requester.
//  Sits between the CPU memory stage and spi; one SPI transaction at a time.
// PARAMETERS
//  FETCH_FIRST  0  1: fetch port wins simultaneous requests; 0: alternate (see arbitration)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  if_req       in   1   fetch request; held with if_addr until if_ack
//  if_addr      in   16  fetch byte address
//  if_ack       out  1   1-cycle pulse: if_rdata valid
//  if_rdata     out  8   fetched byte; holds value until next if_ack
//  d_req        in   1   data request; held with d_we/d_addr/d_wdata until d_ack
//  d_we         in   1   1 = write, 0 = read
//  d_addr       in   16  data byte address
//  d_wdata      in   8   write byte
//  d_ack        out  1   1-cycle pulse: access complete (d_rdata valid on reads)
//  d_rdata      out  8   read byte; holds value until next read d_ack
//  busy         out  1   1 while any state other than IDLE
//  spi_start    out  1   1-cycle start pulse to spi
//  spi_write    out  1   to spi write; stable START..WAIT
//  spi_address  out  16  to spi address; stable START..WAIT
//  spi_databus  out  8   to spi databus; stable START..WAIT (0 on reads)
//  spi_done     in   1   1-cycle completion pulse from spi
//  spi_data     in   8   read byte from spi; valid in spi_done cycle
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, last_grant=fetch, cache invalid.
//  - FSM: IDLE -> START -> WAIT -> RESP -> IDLE.
//    IDLE : sample reqs; on winner latch write/addr/wdata into spi_* regs, -> START.
//    START: spi_start=1 for exactly this cycle, -> WAIT.
//    WAIT : spi_start=0; spi_* held (spi samples address/databus late in its
//           sequence, so no change allowed); on spi_done capture spi_data -> RESP.
//    RESP : pulse winner's ack; rdata register updated on reads; -> IDLE.
//  - Latency: req seen cycle N -> spi_start N+1 -> ack 1 cycle after spi_done.
//  - Requests are level; a req still high in the IDLE cycle after ack is treated
//    as a new request (requester must drop req in the ack cycle if done).
//  - Arbitration (FETCH_FIRST=0): both pending -> grant port not in last_grant;
//    single pending -> grant it. FETCH_FIRST=1: fetch always wins ties.
//  - Requests are never sampled outside IDLE; changes mid-transaction are ignored.
//  - spi_done outside WAIT is ignored. No timeout; WAIT persists until spi_done.
//  - rst mid-transaction: FSM to IDLE next edge, no ack issued; spi reset by the
//    same rst.
//  - Write: d_ack in RESP, d_rdata unchanged.
// CONFIGURATION
//  MEM_BRIDGE_FCACHE_EN defined: single-entry fetch cache (tag 16b, byte, valid).
//   - IDLE with fetch granted and if_addr==tag and valid: no SPI access; state
//     -> RESP directly, if_ack 1 cycle after req seen.
//   - Every SPI fetch read fills tag/byte, sets valid.
//   - Data write with d_addr==tag updates cached byte (write-through to SPI).
//   - Data reads never use or fill the cache.
//  Not defined: no cache logic; every fetch goes to SPI.
// TESTING
//  - d_req=1,d_we=0,d_addr=16'h1234; model returns 8'hA5 -> spi_start once,
//    spi_write=0, spi_address=1234 stable to done; d_ack 1 cyc after done, d_rdata=A5.
//  - d_we=1,d_addr=0x00FF,d_wdata=0x3C -> spi_write=1, spi_databus=3C held to
//    spi_done; d_ack pulse; d_rdata unchanged.
//  - if_req and d_req same cycle, both held, FETCH_FIRST=0 -> data served first
//    (last_grant=fetch after reset), then fetch; no lost/duplicate acks.
//  - rst asserted in WAIT -> busy=0, no ack, next req starts a clean transaction.
//  - FCACHE_EN: fetch 0x0010 (data 0x77) twice -> second if_ack 1 cyc after req,
//    no spi_start; d write 0x0010=0x99 then fetch -> if_rdata=0x99, no spi_start.
//  - spi_done pulse injected while IDLE -> no ack, state stays IDLE.

Source files
------------

// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: arbitrates CPU fetch and data requests onto one SPI memory
// engine, one transaction at a time. The SPI request fields are held stable
// from START until spi_done, and the result goes back to the requester that
// won arbitration.
// Optional feature: define MEM_BRIDGE_FCACHE_EN to add a single-entry fetch
// cache. A fetch that hits the cache is answered without an SPI access.
module spi_mem_bridge #(
  parameter bit FETCH_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [7:0]  if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [7:0]  d_wdata,
  output logic        d_ack,
  output logic [7:0]  d_rdata,
  output logic        busy,
  output logic        spi_start,
  output logic        spi_write,
  output logic [15:0] spi_address,
  output logic [7:0]  spi_databus,
  input  logic        spi_done,
  input  logic [7:0]  spi_data
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic        grant_data_reg, grant_data_next;   // owner of current transaction: 1 = data port
  logic        last_data_reg, last_data_next;     // last grant went to the data port
  logic        spi_write_reg, spi_write_next;
  logic [15:0] spi_address_reg, spi_address_next;
  logic [7:0]  spi_databus_reg, spi_databus_next;
  logic [7:0]  if_rdata_reg, if_rdata_next;
  logic [7:0]  d_rdata_reg, d_rdata_next;
  logic        pick_data;
  logic        cache_hit;
  logic [7:0]  cache_byte;

`ifdef MEM_BRIDGE_FCACHE_EN
  logic [15:0] tag_reg, tag_next;
  logic [7:0]  byte_reg, byte_next;
  logic        valid_reg, valid_next;

  assign cache_hit  = valid_reg && (tag_reg == if_addr);
  assign cache_byte = byte_reg;
`else
  assign cache_hit  = 1'b0;
  assign cache_byte = 8'h00;
`endif

  // Both pending: alternate away from the last grant, unless fetch is preferred.
  always_comb begin
    pick_data = d_req;
    if (if_req && d_req) begin
      pick_data = FETCH_FIRST ? 1'b0 : ~last_data_reg;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next       = state_reg;
    grant_data_next  = grant_data_reg;
    last_data_next   = last_data_reg;
    spi_write_next   = spi_write_reg;
    spi_address_next = spi_address_reg;
    spi_databus_next = spi_databus_reg;
    if_rdata_next    = if_rdata_reg;
    d_rdata_next     = d_rdata_reg;
`ifdef MEM_BRIDGE_FCACHE_EN
    tag_next         = tag_reg;
    byte_next        = byte_reg;
    valid_next       = valid_reg;
`endif
    busy      = (state_reg != IDLE);
    spi_start = (state_reg == START);
    if_ack    = (state_reg == RESP) && !grant_data_reg;
    d_ack     = (state_reg == RESP) && grant_data_reg;

    case (state_reg)
      IDLE: begin
        if (if_req || d_req) begin
          grant_data_next = pick_data;
          last_data_next  = pick_data;
          if (pick_data) begin
            spi_write_next   = d_we;
            spi_address_next = d_addr;
            spi_databus_next = d_we ? d_wdata : 8'h00;
            state_next       = START;
          end else if (cache_hit) begin
            // Cached fetch: answer directly, SPI request fields left untouched.
            if_rdata_next = cache_byte;
            state_next    = RESP;
          end else begin
            spi_write_next   = 1'b0;
            spi_address_next = if_addr;
            spi_databus_next = 8'h00;
            state_next       = START;
          end
        end
      end
      START: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (spi_done) begin
          state_next = RESP;
          // Load the read byte now so it is already valid alongside the ack.
          if (grant_data_reg) begin
            if (!spi_write_reg) begin
              d_rdata_next = spi_data;
            end
          end else begin
            if_rdata_next = spi_data;
          end
`ifdef MEM_BRIDGE_FCACHE_EN
          if (!grant_data_reg) begin
            tag_next   = spi_address_reg;
            byte_next  = spi_data;
            valid_next = 1'b1;
          end else if (spi_write_reg && valid_reg && (tag_reg == spi_address_reg)) begin
            byte_next = spi_databus_reg;
          end
`endif
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      grant_data_reg  <= 1'b0;
      last_data_reg   <= 1'b0;
      spi_write_reg   <= 1'b0;
      spi_address_reg <= 16'h0000;
      spi_databus_reg <= 8'h00;
      if_rdata_reg    <= 8'h00;
      d_rdata_reg     <= 8'h00;
    end else begin
      state_reg       <= state_next;
      grant_data_reg  <= grant_data_next;
      last_data_reg   <= last_data_next;
      spi_write_reg   <= spi_write_next;
      spi_address_reg <= spi_address_next;
      spi_databus_reg <= spi_databus_next;
      if_rdata_reg    <= if_rdata_next;
      d_rdata_reg     <= d_rdata_next;
    end
  end

`ifdef MEM_BRIDGE_FCACHE_EN
  // Fetch cache entry; reset leaves it invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_reg   <= 16'h0000;
      byte_reg  <= 8'h00;
      valid_reg <= 1'b0;
    end else begin
      tag_reg   <= tag_next;
      byte_reg  <= byte_next;
      valid_reg <= valid_next;
    end
  end
`endif

  assign spi_write   = spi_write_reg;
  assign spi_address = spi_address_reg;
  assign spi_databus = spi_databus_reg;
  assign if_rdata    = if_rdata_reg;
  assign d_rdata     = d_rdata_reg;

endmodule
